// File: rtl/frame_write_if.sv
// Pixel-stream / BRAM-write bundle between the camera path, the frame write
// controller and the VGA side.
interface frame_write_if #(
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 19
);
    logic              frame_start;
    logic              frame_done;
    logic              pix_valid;
    logic [PIX_W-1:0]  pix_data;
    logic              disp_frame_done;
    logic              wr_en;
    logic [ADDR_W:0]   wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              rd_buf;
    logic              frame_ready;
    logic [15:0]       frame_cnt;
    logic [15:0]       drop_cnt;
    logic              err_long;

    modport master (
        output frame_start, frame_done, pix_valid, pix_data, disp_frame_done,
        input  wr_en, wr_addr, wr_data, rd_buf, frame_ready, frame_cnt,
               drop_cnt, err_long
    );

    modport slave (
        input  frame_start, frame_done, pix_valid, pix_data, disp_frame_done,
        output wr_en, wr_addr, wr_data, rd_buf, frame_ready, frame_cnt,
               drop_cnt, err_long
    );
endinterface

// File: rtl/frame_write_ctrl.sv
// Camera-to-BRAM frame writer: decimation, row/column tracking, short/long
// frame detection and ping-pong buffering swapped on the VGA frame boundary.
module frame_write_ctrl #(
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int DEC_LOG2 = 0,
    parameter int PIX_W    = 12,
    parameter int ADDR_W   = 19
) (
    input logic         sysclk,
    input logic         sysrst_n,
    frame_write_if.slave bus
);
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = $clog2(IMG_H + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_END  = ROW_W'(IMG_H);
    localparam logic [COL_W-1:0] COL_MASK = COL_W'((1 << DEC_LOG2) - 1);
    localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'((1 << DEC_LOG2) - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge sysclk or negedge sysrst_n) begin
        if (!sysrst_n) rst_sync_q <= 2'b00;
        else           rst_sync_q <= {rst_sync_q[0], 1'b1};
    end

    assign rst_n = rst_sync_q[1];

    logic [1:0]        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic              wr_buf_q, wr_buf_d;
    logic              bad_q, bad_d;
    logic              pending_q, pending_d;
    logic              rd_buf_q, rd_buf_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              frame_ready_q, frame_ready_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              err_long_q, err_long_d;

    logic swap;
    logic drop_inc;
    logic keep;
    logic frame_full;

    assign swap       = bus.disp_frame_done && pending_q;
    assign keep       = ((col_q & COL_MASK) == '0) && ((row_q & ROW_MASK) == '0);
    assign frame_full = (row_q == ROW_END) && (col_q == '0);

    // NOTE: every variable assigned here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        offset_d      = offset_q;
        wr_buf_d      = wr_buf_q;
        bad_d         = bad_q;
        pending_d     = pending_q;
        rd_buf_d      = rd_buf_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_ready_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        err_long_d    = err_long_q;
        drop_inc      = 1'b0;

        if (swap) begin
            rd_buf_d  = ~rd_buf_q;
            pending_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.frame_start) begin
                    state_d  = S_ACTIVE;
                    col_d    = '0;
                    row_d    = '0;
                    offset_d = '0;
                    bad_d    = 1'b0;
                    wr_buf_d = ~rd_buf_d;
                    // A committed frame not yet shown gets overwritten.
                    if (pending_q && !swap) begin
                        pending_d = 1'b0;
                        drop_inc  = 1'b1;
                    end
                end
            end

            S_ACTIVE: begin
                if (bus.frame_start) begin
                    drop_inc = 1'b1;
                    col_d    = '0;
                    row_d    = '0;
                    offset_d = '0;
                    bad_d    = 1'b0;
                end else begin
                    if (bus.pix_valid) begin
                        if (row_q == ROW_END) begin
                            bad_d      = 1'b1;
                            err_long_d = 1'b1;
                        end else begin
                            if (keep) begin
                                wr_en_d   = 1'b1;
                                wr_data_d = bus.pix_data;
                                wr_addr_d = {wr_buf_q, offset_q};
                                offset_d  = offset_q + 1'b1;
                            end
                            if (col_q == COL_LAST) begin
                                col_d = '0;
                                row_d = row_q + 1'b1;
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    end
                    if (bus.frame_done) state_d = S_COMMIT;
                end
            end

            S_COMMIT: begin
                state_d = S_IDLE;
                if (frame_full && !bad_q) begin
                    pending_d     = 1'b1;
                    frame_ready_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 16'd1;
                end else begin
                    drop_inc = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        drop_cnt_d = (drop_inc && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1
                                                             : drop_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            col_q         <= '0;
            row_q         <= '0;
            offset_q      <= '0;
            wr_buf_q      <= 1'b0;
            bad_q         <= 1'b0;
            pending_q     <= 1'b0;
            rd_buf_q      <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_ready_q <= 1'b0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            err_long_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            offset_q      <= offset_d;
            wr_buf_q      <= wr_buf_d;
            bad_q         <= bad_d;
            pending_q     <= pending_d;
            rd_buf_q      <= rd_buf_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_ready_q <= frame_ready_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            err_long_q    <= err_long_d;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.rd_buf      = rd_buf_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.frame_cnt   = frame_cnt_q;
    assign bus.drop_cnt    = drop_cnt_q;
    assign bus.err_long    = err_long_q;
endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed bench for frame_write_ctrl: an 8x4 full-rate instance and an 8x4
// instance decimated by 2 share the same stimulus.
module tb_frame_write_ctrl;
    localparam int PIX_W  = 12;
    localparam int ADDR_W = 19;

    logic sysclk = 1'b0;
    logic sysrst_n = 1'b0;
    always #5 sysclk = ~sysclk;

    logic             frame_start = 1'b0;
    logic             frame_done = 1'b0;
    logic             pix_valid = 1'b0;
    logic [PIX_W-1:0] pix_data = '0;
    logic             disp_frame_done = 1'b0;

    frame_write_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) if0 ();
    frame_write_if #(.PIX_W(PIX_W), .ADDR_W(ADDR_W)) if1 ();

    assign if0.frame_start     = frame_start;
    assign if0.frame_done      = frame_done;
    assign if0.pix_valid       = pix_valid;
    assign if0.pix_data        = pix_data;
    assign if0.disp_frame_done = disp_frame_done;
    assign if1.frame_start     = frame_start;
    assign if1.frame_done      = frame_done;
    assign if1.pix_valid       = pix_valid;
    assign if1.pix_data        = pix_data;
    assign if1.disp_frame_done = disp_frame_done;

    frame_write_ctrl #(.IMG_W(8), .IMG_H(4), .DEC_LOG2(0), .PIX_W(PIX_W), .ADDR_W(ADDR_W))
        dut0 (.sysclk(sysclk), .sysrst_n(sysrst_n), .bus(if0));
    frame_write_ctrl #(.IMG_W(8), .IMG_H(4), .DEC_LOG2(1), .PIX_W(PIX_W), .ADDR_W(ADDR_W))
        dut1 (.sysclk(sysclk), .sysrst_n(sysrst_n), .bus(if1));

    int compared = 0;
    int mismatched = 0;

    // Write/ready logs, sampled on the falling edge.
    logic [ADDR_W:0]  addr0 [64];
    logic [PIX_W-1:0] data0 [64];
    logic [ADDR_W:0]  addr1 [64];
    logic [PIX_W-1:0] data1 [64];
    int n0 = 0, n1 = 0, rdy0 = 0, rdy1 = 0;

    always @(negedge sysclk) begin
        if (if0.wr_en === 1'b1) begin
            if (n0 < 64) begin addr0[n0] = if0.wr_addr; data0[n0] = if0.wr_data; end
            n0++;
        end
        if (if1.wr_en === 1'b1) begin
            if (n1 < 64) begin addr1[n1] = if1.wr_addr; data1[n1] = if1.wr_data; end
            n1++;
        end
        if (if0.frame_ready === 1'b1) rdy0++;
        if (if1.frame_ready === 1'b1) rdy1++;
    end

    task automatic clear_logs();
        n0 = 0; n1 = 0; rdy0 = 0; rdy1 = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic start_frame();
        @(negedge sysclk); frame_start = 1'b1;
        @(negedge sysclk); frame_start = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge sysclk); frame_done = 1'b1;
        @(negedge sysclk); frame_done = 1'b0;
        idle(3);
    endtask

    task automatic disp_pulse();
        @(negedge sysclk); disp_frame_done = 1'b1;
        @(negedge sysclk); disp_frame_done = 1'b0;
        idle(2);
    endtask

    task automatic send_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge sysclk);
            pix_valid = 1'b1;
            pix_data  = PIX_W'(i);
        end
        @(negedge sysclk);
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        sysrst_n = 1'b0;
        idle(3);
        sysrst_n = 1'b1;
        idle(4);
        compared++;
        if (if0.wr_en !== 1'b0) begin mismatched++; $display("FAIL reset_wr_en: got %b want 0", if0.wr_en); end
        compared++;
        if (if0.wr_addr !== '0) begin mismatched++; $display("FAIL reset_wr_addr: got %h want 0", if0.wr_addr); end
        compared++;
        if (if0.rd_buf !== 1'b0) begin mismatched++; $display("FAIL reset_rd_buf: got %b want 0", if0.rd_buf); end
        compared++;
        if (if0.frame_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_frame_cnt: got %0d want 0", if0.frame_cnt); end
        compared++;
        if (if0.drop_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_drop_cnt: got %0d want 0", if0.drop_cnt); end
        compared++;
        if (if0.err_long !== 1'b0 || if0.frame_ready !== 1'b0) begin
            mismatched++; $display("FAIL reset_flags: got err_long=%b frame_ready=%b want 0/0", if0.err_long, if0.frame_ready);
        end
    endtask

    task automatic test_nominal();
        clear_logs();
        start_frame();
        for (int i = 0; i < 32; i++) begin
            @(negedge sysclk);
            if (i == 0) begin
                compared++;
                if (if0.wr_en !== 1'b0) begin mismatched++; $display("FAIL nom_no_early_write: got wr_en=%b want 0", if0.wr_en); end
            end
            if (i == 1) begin
                compared++;
                if (if0.wr_en !== 1'b1 || if0.wr_data !== 12'd0) begin
                    mismatched++; $display("FAIL nom_latency: got wr_en=%b data=%0d want 1/0", if0.wr_en, if0.wr_data);
                end
            end
            pix_valid = 1'b1;
            pix_data  = PIX_W'(i);
        end
        @(negedge sysclk);
        pix_valid = 1'b0;
        end_frame();
        compared++;
        if (n0 !== 32) begin mismatched++; $display("FAIL nom_write_count: got %0d want 32", n0); end
        for (int i = 0; i < 32 && i < n0; i++) begin
            logic [ADDR_W:0] ea;
            ea = 20'h80000 + 20'(i);
            compared++;
            if (addr0[i] !== ea || data0[i] !== PIX_W'(i)) begin
                mismatched++; $display("FAIL nom_write[%0d]: got %h/%0d want %h/%0d", i, addr0[i], data0[i], ea, i);
            end
        end
        compared++;
        if (rdy0 !== 1) begin mismatched++; $display("FAIL nom_frame_ready: got %0d pulses want 1", rdy0); end
        compared++;
        if (if0.frame_cnt !== 16'd1) begin mismatched++; $display("FAIL nom_frame_cnt: got %0d want 1", if0.frame_cnt); end
        compared++;
        if (if0.rd_buf !== 1'b0) begin mismatched++; $display("FAIL nom_rd_buf_before: got %b want 0", if0.rd_buf); end
        disp_pulse();
        compared++;
        if (if0.rd_buf !== 1'b1) begin mismatched++; $display("FAIL nom_rd_buf_swap: got %b want 1", if0.rd_buf); end
    endtask

    task automatic test_decimation();
        logic [PIX_W-1:0] exp_d [8];
        exp_d = '{12'd0, 12'd2, 12'd4, 12'd6, 12'd16, 12'd18, 12'd20, 12'd22};
        clear_logs();
        start_frame();
        send_pixels(32);
        end_frame();
        compared++;
        if (n1 !== 8) begin mismatched++; $display("FAIL dec_write_count: got %0d want 8", n1); end
        for (int i = 0; i < 8 && i < n1; i++) begin
            compared++;
            if (addr1[i] !== 20'(i) || data1[i] !== exp_d[i]) begin
                mismatched++; $display("FAIL dec_write[%0d]: got %h/%0d want %h/%0d", i, addr1[i], data1[i], i, exp_d[i]);
            end
        end
        compared++;
        if (rdy1 !== 1 || if1.frame_cnt !== 16'd2) begin
            mismatched++; $display("FAIL dec_commit: got ready=%0d cnt=%0d want 1/2", rdy1, if1.frame_cnt);
        end
        disp_pulse();
        compared++;
        if (if0.rd_buf !== 1'b0) begin mismatched++; $display("FAIL dec_rd_buf_swap: got %b want 0", if0.rd_buf); end
    endtask

    task automatic test_short_long();
        clear_logs();
        start_frame();
        send_pixels(31);
        end_frame();
        compared++;
        if (if0.drop_cnt !== 16'd1 || rdy0 !== 0) begin
            mismatched++; $display("FAIL short_drop: got drop=%0d ready=%0d want 1/0", if0.drop_cnt, rdy0);
        end
        compared++;
        if (if0.frame_cnt !== 16'd2) begin mismatched++; $display("FAIL short_frame_cnt: got %0d want 2", if0.frame_cnt); end
        disp_pulse();
        compared++;
        if (if0.rd_buf !== 1'b0) begin mismatched++; $display("FAIL short_rd_buf_hold: got %b want 0", if0.rd_buf); end

        clear_logs();
        start_frame();
        send_pixels(33);
        end_frame();
        compared++;
        if (n0 !== 32) begin mismatched++; $display("FAIL long_write_count: got %0d want 32", n0); end
        compared++;
        if (n0 >= 32 && addr0[31] !== 20'h8001F) begin
            mismatched++; $display("FAIL long_last_addr: got %h want 8001f", addr0[31]);
        end
        compared++;
        if (if0.err_long !== 1'b1) begin mismatched++; $display("FAIL long_err: got %b want 1", if0.err_long); end
        compared++;
        if (if0.drop_cnt !== 16'd2 || rdy0 !== 0) begin
            mismatched++; $display("FAIL long_drop: got drop=%0d ready=%0d want 2/0", if0.drop_cnt, rdy0);
        end
    endtask

    task automatic test_overwrite();
        clear_logs();
        start_frame();
        send_pixels(32);
        end_frame();
        compared++;
        if (if0.frame_cnt !== 16'd3 || rdy0 !== 1) begin
            mismatched++; $display("FAIL ovw_first: got cnt=%0d ready=%0d want 3/1", if0.frame_cnt, rdy0);
        end
        clear_logs();
        start_frame();
        send_pixels(32);
        end_frame();
        compared++;
        if (n0 < 1 || addr0[0] !== 20'h80000) begin
            mismatched++; $display("FAIL ovw_same_buf: got n=%0d addr=%h want >0/80000", n0, addr0[0]);
        end
        compared++;
        if (if0.drop_cnt !== 16'd3) begin mismatched++; $display("FAIL ovw_drop: got %0d want 3", if0.drop_cnt); end
        compared++;
        if (if0.frame_cnt !== 16'd4 || if0.rd_buf !== 1'b0) begin
            mismatched++; $display("FAIL ovw_cnt_rd: got cnt=%0d rd=%b want 4/0", if0.frame_cnt, if0.rd_buf);
        end
    endtask

    task automatic test_simultaneous();
        clear_logs();
        @(negedge sysclk);
        frame_start = 1'b1;
        disp_frame_done = 1'b1;
        @(negedge sysclk);
        frame_start = 1'b0;
        disp_frame_done = 1'b0;
        send_pixels(32);
        end_frame();
        compared++;
        if (if0.rd_buf !== 1'b1) begin mismatched++; $display("FAIL sim_rd_buf: got %b want 1", if0.rd_buf); end
        compared++;
        if (n0 !== 32 || addr0[0] !== 20'h00000 || addr0[31] !== 20'h0001F) begin
            mismatched++; $display("FAIL sim_addr: got n=%0d first=%h last=%h want 32/00000/0001f", n0, addr0[0], addr0[31]);
        end
        compared++;
        if (if0.drop_cnt !== 16'd3 || if0.frame_cnt !== 16'd5) begin
            mismatched++; $display("FAIL sim_counts: got drop=%0d cnt=%0d want 3/5", if0.drop_cnt, if0.frame_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        start_frame();
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            pix_valid = 1'b1;
            pix_data  = PIX_W'(i + 5);
        end
        @(posedge sysclk);
        #2;
        sysrst_n  = 1'b0;
        pix_valid = 1'b0;
        #1;
        compared++;
        if (if0.wr_en !== 1'b0 || if0.wr_addr !== '0 || if0.wr_data !== '0) begin
            mismatched++; $display("FAIL rst_mid_write: got en=%b addr=%h data=%h want 0/0/0", if0.wr_en, if0.wr_addr, if0.wr_data);
        end
        compared++;
        if (if0.rd_buf !== 1'b0 || if0.err_long !== 1'b0 || if0.frame_ready !== 1'b0) begin
            mismatched++; $display("FAIL rst_mid_flags: got rd=%b err=%b rdy=%b want 0/0/0", if0.rd_buf, if0.err_long, if0.frame_ready);
        end
        compared++;
        if (if0.frame_cnt !== 16'd0 || if0.drop_cnt !== 16'd0) begin
            mismatched++; $display("FAIL rst_mid_counts: got cnt=%0d drop=%0d want 0/0", if0.frame_cnt, if0.drop_cnt);
        end
        @(negedge sysclk);
        sysrst_n = 1'b1;
        idle(4);
        clear_logs();
        send_pixels(8);
        idle(2);
        compared++;
        if (n0 !== 0) begin mismatched++; $display("FAIL rst_mid_no_writes: got %0d writes want 0", n0); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_decimation();
        test_short_long();
        test_overwrite();
        test_simultaneous();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/frame_write_ctrl.md
Name: frame_write_ctrl

Overview:
- Parametrised successor to the camera-to-BRAM write path.
- Takes the downsampled pixel stream (already in the system clock domain) and generates BRAM write enable, address and data.
- Adds power-of-two decimation, row/column tracking, short/long frame detection and ping-pong double buffering, with the buffer swap synchronised to the VGA frame boundary.
- Sits between pixel_downsample and bram_memory. The VGA read side uses rd_buf as the address MSB.

Parameters:
- IMG_W, 640, input frame width in pixels.
- IMG_H, 480, input frame height in lines.
- DEC_LOG2, 0, decimation exponent; keep every 2^DEC_LOG2-th pixel and line (0 = no decimation).
- PIX_W, 12, pixel width (RGB444).
- ADDR_W, 19, address width within one buffer; must be at least ceil(log2(OUT_W*OUT_H)).
- Derived: OUT_W = IMG_W>>DEC_LOG2, OUT_H = IMG_H>>DEC_LOG2.

Ports:
- sysclk  in  1  system clock.
- sysrst_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse at start of a camera frame.
- frame_done  in  1  single-cycle pulse at end of a camera frame.
- pix_valid  in  1  pix_data valid this cycle.
- pix_data  in  PIX_W  input pixel.
- disp_frame_done  in  1  single-cycle pulse when VGA finishes a frame.
- wr_en  out  1  BRAM write enable.
- wr_addr  out  ADDR_W+1  write address; MSB = wr_buf.
- wr_data  out  PIX_W  write data.
- rd_buf  out  1  buffer the VGA reads.
- frame_ready  out  1  one-cycle pulse on good frame commit.
- frame_cnt  out  16  count of committed frames, wraps.
- drop_cnt  out  16  count of aborted, short, long or overwritten frames; saturates at 0xFFFF.
- err_long  out  1  sticky; set when a frame exceeds IMG_W*IMG_H pixels.

Behaviour:
- Reset (async assert, sync deassert inside block) clears the following: wr_en, wr_addr, wr_data, rd_buf, frame_ready, frame_cnt, drop_cnt, err_long, pending, col, row; FSM goes to IDLE.
- States:
  - IDLE: ignore pix_valid and frame_done. On frame_start: go to ACTIVE; col=row=0; wr_buf=~rd_buf_next; address offset=0.
  - ACTIVE: on each pix_valid, col increments. When col reaches IMG_W-1, col wraps to 0 and row increments.
    - Pixel kept when low DEC_LOG2 bits of col and row are both 0.
    - Kept pixel: wr_en=1, wr_data=pix_data, wr_addr={wr_buf, offset}, then offset++.
    - Latency: exactly 1 cycle from pix_valid to wr_en.
  - ACTIVE, pixel count overflow: pix_valid when row==IMG_H means the pixel is dropped (no write), err_long set, and the frame is marked bad.
  - ACTIVE, frame_done: go to COMMIT.
  - ACTIVE, frame_start: abort; drop_cnt++; restart in ACTIVE with counters zeroed and the same wr_buf.
  - COMMIT (1 cycle):
    - Good frame: exactly IMG_W*IMG_H pixels received and not marked bad. Then pending=1, frame_ready pulse, frame_cnt++.
    - Otherwise: drop_cnt++, pending unchanged.
    - Next state is IDLE.
- Buffer swap:
  - On disp_frame_done with pending=1: rd_buf toggles and pending clears.
  - With pending=0: rd_buf holds, so the VGA repeats the last frame.
- Overwrite: frame_start while pending=1 and no swap in the same cycle means pending clears, drop_cnt++, and the writer reuses the same buffer.
- Simultaneous disp_frame_done and frame_start: the swap is applied first; wr_buf = ~(new rd_buf); pending clears from the swap; no drop.
- Simultaneous pix_valid and frame_done: the pixel is counted before the frame evaluation.
- wr_en is never asserted outside ACTIVE. The writer never targets rd_buf.
- No multipliers: address is an incrementing counter.

Test Plan:
- Nominal frame: IMG_W=8, IMG_H=4, DEC_LOG2=0; frame_start, 32 pix_valid (data = index), frame_done, then disp_frame_done. Expect:
  - 32 writes at addresses 0x80000..0x8001F with data 0..31;
  - frame_ready once; frame_cnt=1;
  - rd_buf 0→1 after disp_frame_done.
- Decimation: DEC_LOG2=1, 8x4 frame. Expect 8 writes (cols 0,2,4,6 of rows 0,2) at offsets 0..7; frame committed.
- Short/long frames:
  - 31 pixels then frame_done: drop_cnt=1, no frame_ready, rd_buf unchanged.
  - 33 pixels: 32 writes, err_long=1, drop_cnt++.
- Overwrite and simultaneous events:
  - Two good frames with no disp_frame_done: the second writes the same buffer; drop_cnt=1; frame_cnt=2.
  - disp_frame_done in the same cycle as frame_start: the new frame writes ~new rd_buf; drop_cnt unchanged.
- Reset mid-frame: assert sysrst_n=0 after 10 pixels. Expect all outputs 0 immediately (asynchronous). After release, pix_valid without frame_start produces no writes.
